// File: rtl/snn_layer_sequencer_if.sv
// snn_layer_sequencer_if: host, configuration and neuron-datapath signals of the layer sequencer
interface snn_layer_sequencer_if #(
  parameter int NUM_INPUTS  = 8,
  parameter int NUM_NEURONS = 4,
  parameter int WEIGHT_SIZE = 8,
  parameter int V_MEM_SIZE  = 8,
  parameter int B_SIZE      = 8,
  parameter int AW          = $clog2(NUM_NEURONS * NUM_INPUTS)
);
  logic                   start_i;
  logic [NUM_INPUTS-1:0]  in_spikes_i;
  logic [B_SIZE-1:0]      beta_i;
  logic [V_MEM_SIZE-1:0]  v_th_i;
  logic                   w_we_i;
  logic [AW-1:0]          w_addr_i;
  logic [WEIGHT_SIZE-1:0] w_data_i;
  logic [WEIGHT_SIZE-1:0] n_weight_o;
  logic [V_MEM_SIZE-1:0]  n_v_mem_o;
  logic [B_SIZE-1:0]      n_beta_o;
  logic [V_MEM_SIZE-1:0]  n_v_th_o;
  logic                   n_function_sel_o;
  logic                   n_spike_i;
  logic [V_MEM_SIZE-1:0]  n_v_mem_i;
  logic [NUM_NEURONS-1:0] out_spikes_o;
  logic                   busy_o;
  logic                   done_o;
  modport slave (
    input  start_i, in_spikes_i, beta_i, v_th_i, w_we_i, w_addr_i, w_data_i, n_spike_i, n_v_mem_i,
    output n_weight_o, n_v_mem_o, n_beta_o, n_v_th_o, n_function_sel_o, out_spikes_o, busy_o, done_o
  );
  modport master (
    output start_i, in_spikes_i, beta_i, v_th_i, w_we_i, w_addr_i, w_data_i, n_spike_i, n_v_mem_i,
    input  n_weight_o, n_v_mem_o, n_beta_o, n_v_th_o, n_function_sel_o, out_spikes_o, busy_o, done_o
  );
endinterface

// File: rtl/snn_layer_sequencer.sv
// snn_layer_sequencer: time-multiplexes one LIF datapath over a neuron layer; define SNN_SAT_EN to saturate v_mem on accumulate overflow
module snn_layer_sequencer #(
  parameter int NUM_INPUTS  = 8,
  parameter int NUM_NEURONS = 4,
  parameter int WEIGHT_SIZE = 8,
  parameter int V_MEM_SIZE  = 8,
  parameter int B_SIZE      = 8
) (
  input logic wb_clk_i,
  input logic wb_rst_i,
  snn_layer_sequencer_if.slave bus
);
  localparam int AW = $clog2(NUM_NEURONS * NUM_INPUTS);
  localparam int NW = NUM_NEURONS > 1 ? $clog2(NUM_NEURONS) : 1;
  localparam int IW = NUM_INPUTS > 1 ? $clog2(NUM_INPUTS) : 1;
  typedef enum logic [1:0] {IDLE, DECAY, ACCUM, DONE} state_t;
  state_t                 state_q, state_d;
  logic [NW-1:0]          n_q;
  logic [IW-1:0]          i_q;
  logic [V_MEM_SIZE-1:0]  vmem_q [NUM_NEURONS];
  logic [WEIGHT_SIZE-1:0] w_q [NUM_NEURONS*NUM_INPUTS];
  logic [NUM_INPUTS-1:0]  spk_q;
  logic [B_SIZE-1:0]      beta_q;
  logic [V_MEM_SIZE-1:0]  vth_q;
  logic [NUM_NEURONS-1:0] scr_q, out_q;
  logic [AW-1:0]          widx;
  logic [V_MEM_SIZE-1:0]  cur_v, acc_v;
  logic                   last_i, last_n;
  assign widx   = AW'(int'(n_q) * NUM_INPUTS + int'(i_q));
  assign cur_v  = vmem_q[n_q];
  assign last_i = i_q == IW'(NUM_INPUTS - 1);
  assign last_n = n_q == NW'(NUM_NEURONS - 1);
`ifdef SNN_SAT_EN
  // a wrapped sum is smaller than the addend it started from
  assign acc_v = bus.n_v_mem_i < cur_v ? '1 : bus.n_v_mem_i;
`else
  assign acc_v = bus.n_v_mem_i;
`endif
  assign bus.n_beta_o     = beta_q;
  assign bus.n_v_th_o     = vth_q;
  assign bus.out_spikes_o = out_q;
  assign bus.busy_o       = state_q != IDLE;
  assign bus.done_o       = state_q == DONE;
  always_ff @(posedge wb_clk_i) state_q <= wb_rst_i ? IDLE : state_d;
  always_comb begin
    state_d              = state_q;
    bus.n_function_sel_o = 1'b0;
    bus.n_weight_o       = '0;
    bus.n_v_mem_o        = '0;
    case (state_q)
      IDLE:  state_d = bus.start_i ? DECAY : IDLE;
      DECAY: begin
        state_d              = ACCUM;
        bus.n_function_sel_o = 1'b1;
        bus.n_v_mem_o        = cur_v;
      end
      ACCUM: begin
        state_d        = last_i ? (last_n ? DONE : DECAY) : ACCUM;
        bus.n_weight_o = w_q[widx];
        bus.n_v_mem_o  = cur_v;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      n_q    <= '0;
      i_q    <= '0;
      spk_q  <= '0;
      beta_q <= '0;
      vth_q  <= '0;
      scr_q  <= '0;
      out_q  <= '0;
      vmem_q <= '{default: '0};
      w_q    <= '{default: '0};
    end else begin
      if (state_q == IDLE && bus.w_we_i) w_q[bus.w_addr_i] <= bus.w_data_i;
      if (state_q == IDLE && bus.start_i) begin
        spk_q  <= bus.in_spikes_i;
        beta_q <= bus.beta_i;
        vth_q  <= bus.v_th_i;
        scr_q  <= '0;
        n_q    <= '0;
      end
      if (state_q == DECAY) begin
        vmem_q[n_q] <= bus.n_v_mem_i;
        scr_q[n_q]  <= bus.n_spike_i;
        i_q         <= '0;
      end
      // fixed NUM_INPUTS-cycle sweep; silent inputs just skip the capture
      if (state_q == ACCUM) begin
        if (spk_q[i_q]) vmem_q[n_q] <= acc_v;
        i_q <= i_q + 1'b1;
        n_q <= last_i ? n_q + 1'b1 : n_q;
      end
      if (state_q == DONE) out_q <= scr_q;
    end
  end
endmodule
